// File: rtl/mem_arbiter.sv
// Two-master burst arbiter in front of a single memory port. Each grant covers one
// whole transaction (write burst, or read command plus all returned beats), round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  // master 0
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
  input  logic                      m0_rd,
  input  logic                      m0_wr,
  input  logic [DATA_WIDTH-1:0]     m0_wr_data,
  output logic                      m0_waitrequest,
  output logic [DATA_WIDTH-1:0]     m0_rd_data,
  output logic                      m0_rd_valid,
  // master 1
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
  input  logic                      m1_rd,
  input  logic                      m1_wr,
  input  logic [DATA_WIDTH-1:0]     m1_wr_data,
  output logic                      m1_waitrequest,
  output logic [DATA_WIDTH-1:0]     m1_rd_data,
  output logic                      m1_rd_valid,
  // memory side
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [BURSTLEN_WIDTH-1:0] mem_burst_len,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic                      mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  input  logic                      mem_rd_valid,
  // FSM state for checkers: 0 IDLE, 1 WRITE, 2 READ_CMD, 3 READ_DATA
  output logic [1:0]                o_dbg_state
);

  // Handshake: a read command or write beat transfers on a rising edge where rd/wr is
  // high and waitrequest is low; rd_valid beats carry no backpressure and are taken as seen.

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_READ_CMD  = 2'd2;
  localparam logic [1:0] S_READ_DATA = 2'd3;

  localparam logic [BURSTLEN_WIDTH-1:0] CNT_ONE = BURSTLEN_WIDTH'(1);

  logic [1:0]                r_state;
  logic                      r_grant;
  logic                      r_last;
  logic [BURSTLEN_WIDTH-1:0] r_cnt;
  logic [BURSTLEN_WIDTH-1:0] r_target;

  logic                      w_req0;
  logic                      w_req1;
  logic                      w_pick;
  logic                      w_pick_wr;
  logic [BURSTLEN_WIDTH-1:0] w_pick_len;
  logic [ADDR_WIDTH-1:0]     w_sel_addr;
  logic [BURSTLEN_WIDTH-1:0] w_sel_len;
  logic                      w_sel_rd;
  logic                      w_sel_wr;
  logic [DATA_WIDTH-1:0]     w_sel_wdata;
  logic                      w_fwd;
  logic                      w_rdata_phase;
  logic                      w_wr_beat;
  logic                      w_cmd_acc;
  logic                      w_last_beat;

  assign w_req0 = m0_rd | m0_wr;
  assign w_req1 = m1_rd | m1_wr;

  // On a tie the master that was not served most recently wins.
  assign w_pick     = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_pick_wr  = w_pick ? m1_wr : m0_wr;
  assign w_pick_len = w_pick ? m1_burst_len : m0_burst_len;

  assign w_sel_addr  = r_grant ? m1_addr      : m0_addr;
  assign w_sel_len   = r_grant ? m1_burst_len : m0_burst_len;
  assign w_sel_rd    = r_grant ? m1_rd        : m0_rd;
  assign w_sel_wr    = r_grant ? m1_wr        : m0_wr;
  assign w_sel_wdata = r_grant ? m1_wr_data   : m0_wr_data;

  assign w_fwd         = (r_state == S_WRITE) || (r_state == S_READ_CMD);
  assign w_rdata_phase = (r_state == S_READ_DATA);

  assign mem_addr      = w_sel_addr;
  assign mem_burst_len = w_sel_len;
  assign mem_wr_data   = w_sel_wdata;
  assign mem_wr        = (r_state == S_WRITE) & w_sel_wr;
  assign mem_rd        = (r_state == S_READ_CMD) & w_sel_rd;

  assign m0_waitrequest = (w_fwd && !r_grant) ? mem_waitrequest : 1'b1;
  assign m1_waitrequest = (w_fwd &&  r_grant) ? mem_waitrequest : 1'b1;
  assign m0_rd_valid    = w_rdata_phase & ~r_grant & mem_rd_valid;
  assign m1_rd_valid    = w_rdata_phase &  r_grant & mem_rd_valid;
  assign m0_rd_data     = mem_rd_data;
  assign m1_rd_data     = mem_rd_data;

  assign w_wr_beat   = mem_wr & ~mem_waitrequest;
  assign w_cmd_acc   = mem_rd & ~mem_waitrequest;
  assign w_last_beat = (r_cnt == r_target);

  assign o_dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_target <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant  <= w_pick;
            r_target <= w_pick_len;
            r_cnt    <= '0;
            r_state  <= w_pick_wr ? S_WRITE : S_READ_CMD;
          end
        end
        S_WRITE: begin
          if (w_wr_beat) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last_beat) begin
              r_last  <= r_grant;
              r_state <= S_IDLE;
            end
          end
        end
        S_READ_CMD: begin
          if (w_cmd_acc) r_state <= S_READ_DATA;
        end
        S_READ_DATA: begin
          // Completion always returns to IDLE, giving one idle cycle before the next grant.
          if (mem_rd_valid) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last_beat) begin
              r_last  <= r_grant;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two master drivers, a burst memory model with random stalls
// and read gaps, and a per-master scoreboard fed from a reference memory image.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 2;
  localparam int TMO = 200;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] m_addr  [2];
  logic [LW-1:0] m_len   [2];
  logic [DW-1:0] m_wdata [2];
  logic [1:0]    m_rd;
  logic [1:0]    m_wr;
  wire  [1:0]    m_wait;
  wire  [1:0]    m_rv;
  logic [DW-1:0] m0_rdata;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_burst_len;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset),
    .m0_addr(m_addr[0]), .m0_burst_len(m_len[0]), .m0_rd(m_rd[0]), .m0_wr(m_wr[0]),
    .m0_wr_data(m_wdata[0]), .m0_waitrequest(m_wait[0]), .m0_rd_data(m0_rdata),
    .m0_rd_valid(m_rv[0]),
    .m1_addr(m_addr[1]), .m1_burst_len(m_len[1]), .m1_rd(m_rd[1]), .m1_wr(m_wr[1]),
    .m1_wr_data(m_wdata[1]), .m1_waitrequest(m_wait[1]), .m1_rd_data(m1_rdata),
    .m1_rd_valid(m_rv[1]),
    .mem_addr(mem_addr), .mem_burst_len(mem_burst_len), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wr_data(mem_wr_data), .mem_waitrequest(mem_waitrequest),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .o_dbg_state(dbg_state)
  );

  // reference memory image, memory model storage, scoreboard
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            rx_cnt[2] = '{0, 0};
  int            done_q[$];
  int            n_chk = 0;
  int            n_bad = 0;
  int            wbeat = 0;
  bit            rnd_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Unwritten memory holds word index i at byte address i<<2.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a >> 2;
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  // memory model: drive stall / read beats after each edge
  initial begin
    mem_waitrequest = 1'b0;
    mem_rd_valid    = 1'b0;
    mem_rd_data     = '0;
    forever begin
      @(posedge clock);
      #1;
      mem_waitrequest = rnd_en && ($urandom_range(0, 2) == 0);
      if (rsp_q.size() > 0 && (!rnd_en || $urandom_range(0, 3) != 0)) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = rsp_q.pop_front();
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = $urandom;
      end
    end
  end

  // memory model: accept commands and write beats
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        wbeat = 0;
      end else begin
        if (mem_wr && !mem_waitrequest) begin
          mem_arr[mem_addr + AW'(4 * wbeat)] = mem_wr_data;
          if (wbeat == int'(mem_burst_len)) wbeat = 0;
          else wbeat++;
        end
        if (mem_rd && !mem_waitrequest)
          for (int i = 0; i <= int'(mem_burst_len); i++)
            rsp_q.push_back(mem_word(mem_addr + AW'(4 * i)));
      end
    end
  end

  // scoreboard / protocol monitor
  initial begin
    forever begin
      @(negedge clock);
      if (mem_rd | mem_wr) check("rd_wr_excl", 64'(mem_rd & mem_wr), 0);
      if (m_rv != 2'b00) begin
        check("rv_without_mem_valid", 64'(m_rv & {2{~mem_rd_valid}}), 0);
        check("rv_both", 64'(m_rv == 2'b11), 0);
      end
      if (m_rv[0]) begin
        if (exp_q0.size() == 0) check("rv0_spurious", 1, 0);
        else check("rd0_data", m0_rdata, exp_q0.pop_front());
        rx_cnt[0]++;
      end
      if (m_rv[1]) begin
        if (exp_q1.size() == 0) check("rv1_spurious", 1, 0);
        else check("rd1_data", m1_rdata, exp_q1.pop_front());
        rx_cnt[1]++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks: called and returning at posedge+1
  task automatic wait_accept(input int m, output int lat);
    bit acc;
    lat = 0;
    forever begin
      @(negedge clock);
      acc = !m_wait[m];
      @(posedge clock);
      #1;
      lat++;
      if (acc) break;
      if (lat >= TMO) begin
        check($sformatf("m%0d_accept_tmo", m), 1, 0);
        break;
      end
    end
  endtask

  task automatic read_txn(input int m, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          output int lat);
    int tgt;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      if (m == 0) exp_q0.push_back(ref_word(addr + AW'(4 * i)));
      else        exp_q1.push_back(ref_word(addr + AW'(4 * i)));
    end
    tgt = rx_cnt[m] + int'(len) + 1;
    m_addr[m] = addr;
    m_len[m]  = len;
    m_rd[m]   = 1'b1;
    wait_accept(m, lat);
    m_rd[m] = 1'b0;
    n = 0;
    while (rx_cnt[m] < tgt && n < TMO) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (rx_cnt[m] < tgt) check($sformatf("m%0d_rd_beats_tmo", m), rx_cnt[m], tgt);
    done_q.push_back(m);
  endtask

  task automatic write_txn(input int m, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [DW-1:0] base);
    int lat;
    for (int i = 0; i <= int'(len); i++) ref_mem[addr + AW'(4 * i)] = base + DW'(i);
    m_addr[m] = addr;
    m_len[m]  = len;
    for (int i = 0; i <= int'(len); i++) begin
      m_wr[m]    = 1'b1;
      m_wdata[m] = base + DW'(i);
      wait_accept(m, lat);
    end
    m_wr[m] = 1'b0;
    done_q.push_back(m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_rd  = 2'b00;
    m_wr  = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int lat0, lat1, lat2, r0, r1, n;
  int exp_order[5] = '{0, 1, 0, 1, 0};
  int cyc, beats, c4, cw;
  bit low_seen;

  initial begin
    m_rd = 2'b00;
    m_wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_addr[i]  = '0;
      m_len[i]   = '0;
      m_wdata[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_rd", 64'(mem_rd), 0);
    check("rst_mem_wr", 64'(mem_wr), 0);
    check("rst_wait", 64'(m_wait), 2'b11);
    check("rst_rv", 64'(m_rv), 0);
    reset = 1'b0;

    // m0 only read, 4 beats of preloaded words 0x40..0x43, zero-wait memory
    read_txn(0, 32'h100, 2'd3, lat0);
    check("t1_cmd_lat", lat0, 2);
    check("t1_beats", rx_cnt[0], 4);

    // m1 only write burst with random stalls
    rnd_en = 1'b1;
    write_txn(1, 32'h2000, 2'd3, 32'hA0);
    repeat (4) begin
      @(negedge clock);
      check("t2_no_wr_after", 64'(mem_wr), 0);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_mem%0d", i), mem_word(32'h2000 + AW'(4 * i)), 32'hA0 + i);

    // simultaneous requests after reset, then a second round
    do_reset();
    done_q.delete();
    fork
      begin
        read_txn(0, 32'h400, 2'd1, lat0);
        read_txn(0, 32'h500, 2'd0, lat0);
      end
      read_txn(1, 32'h600, 2'd2, lat1);
    join
    fork
      read_txn(0, 32'h700, 2'd1, lat0);
      read_txn(1, 32'h800, 2'd1, lat1);
    join
    check("t3_count", done_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_order%0d", i), (i < done_q.size()) ? done_q[i] : -1, exp_order[i]);

    // m0 read holds off m1 write; write begins two cycles after the last read beat
    cyc = 0; beats = 0; c4 = -1; cw = -1; low_seen = 1'b0;
    fork
      read_txn(0, 32'h900, 2'd3, lat0);
      begin
        @(posedge clock);
        #1;
        write_txn(1, 32'h3000, 2'd3, $urandom);
      end
      begin
        while (cw < 0 && cyc < TMO) begin
          @(negedge clock);
          cyc++;
          if (c4 < 0) begin
            if (!m_wait[1]) low_seen = 1'b1;
            if (m_rv[0]) begin
              beats++;
              if (beats == 4) c4 = cyc;
            end
          end else if (mem_wr) begin
            cw = cyc;
          end
        end
      end
    join
    check("t4_m1_wait_held", 64'(low_seen), 0);
    check("t4_last_beat_seen", 64'(c4 > 0), 1);
    check("t4_wr_gap", cw - c4, 2);

    // single-beat write then read back
    write_txn(0, 32'h3FC, 2'd0, 32'hDEADBEEF);
    check("t5_mem", mem_word(32'h3FC), 32'hDEADBEEF);
    r0 = rx_cnt[0];
    read_txn(0, 32'h3FC, 2'd0, lat0);
    repeat (3) @(posedge clock);
    #1;
    check("t5_single_beat", rx_cnt[0] - r0, 1);

    // reset in the middle of a read data phase
    rnd_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q0.push_back(ref_word(32'hA00 + AW'(4 * i)));
    m_addr[0] = 32'hA00;
    m_len[0]  = 2'd3;
    m_rd[0]   = 1'b1;
    wait_accept(0, lat0);
    m_rd[0] = 1'b0;
    n = 0;
    while (exp_q0.size() > 2 && n < TMO) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("t6_two_beats", exp_q0.size(), 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_mem_rd", 64'(mem_rd), 0);
    check("t6_mem_wr", 64'(mem_wr), 0);
    check("t6_wait", 64'(m_wait), 2'b11);
    check("t6_rv", 64'(m_rv), 0);
    reset = 1'b0;
    exp_q0.delete();
    n = 0;
    while (rsp_q.size() > 0 && n < TMO) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    rnd_en = 1'b1;
    r1 = rx_cnt[1];
    read_txn(1, 32'h4000, 2'd3, lat2);
    check("t6_m1_beats", rx_cnt[1] - r1, 4);

    // random concurrent traffic, disjoint address regions per master
    fork
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 1) == 1)
          write_txn(0, 32'h10000 + AW'($urandom_range(0, 31) << 2), LW'($urandom_range(0, 3)), $urandom);
        else
          read_txn(0, 32'h10000 + AW'($urandom_range(0, 31) << 2), LW'($urandom_range(0, 3)), lat0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clock);
          #1;
        end
      end
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 1) == 1)
          write_txn(1, 32'h20000 + AW'($urandom_range(0, 31) << 2), LW'($urandom_range(0, 3)), $urandom);
        else
          read_txn(1, 32'h20000 + AW'($urandom_range(0, 31) << 2), LW'($urandom_range(0, 3)), lat1);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clock);
          #1;
        end
      end
    join
    repeat (5) @(posedge clock);
    #1;
    check("rand_q0_empty", exp_q0.size(), 0);
    check("rand_q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
